dec_pipe: RTL and testbench
===========================

DEC_PIPE -- requirements
Module: dec_pipe

Interface
REQ-001 SHALL have parameter NREG, default 32, number of architectural registers (16 or 32 only).
REQ-002 SHALL have parameter SB_DEPTH, default 2, number of in-flight destination registers tracked (1..4).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports instr_i  in  32  instruction; instr_addr_i  in  32  its address; instr_valid_i  in  1  instruction present.
REQ-006 SHALL have port instr_ready_o  out  1  decode accepts instr_i this cycle.
REQ-007 SHALL have port flush_i  in  1  branch redirect from execute; kill the instruction in decode.
REQ-008 SHALL have ports wb_rd_i  in  5  writeback register (0 = none); wb_data_i  in  32  writeback data.
REQ-009 SHALL have registered outputs: valid_o 1; opcode_o 11; rs1_data_o 32; rs2_data_o 32; imm_o 32; rd_o 5; instr_addr_o 32; shamt_o 5; illegal_o 1.

Function
REQ-010 SHALL register all outputs, with one-cycle latency from acceptance to valid_o.
REQ-011 SHALL form opcode_o as {(instr[31:25]!=0), funct3, instr[6:0]}.
REQ-012 SHALL decode LUI/AUIPC/JAL/JALR/BRANCH/LOAD/STORE/OP-IMM/OP with the standard RV32I rs1/rs2/rd usage; FENCE/SYSTEM use no registers.
REQ-013 SHALL produce imm_o sign-extended to 32 bits per the I/S/B/U/J format; for B/J, bit 0 = 0; for U, the low 12 bits are 0; for other opcodes, 0.
REQ-014 SHALL set shamt_o to instr[24:20] for SLLI/SRLI/SRAI, otherwise 0.
REQ-015 SHALL hold scoreboard sb[0..SB_DEPTH-1] of rd numbers; each accepted non-flushed instruction shifts its rd (0 if none) into sb[0].
REQ-016 SHALL assert stall when instr_valid_i & ~flush_i and a used, nonzero rs1 or rs2 equals any sb entry.
REQ-017 SHALL drive instr_ready_o = ~stall (combinational).
REQ-018 SHALL, on stall, emit a bubble (valid_o=0, all other outputs 0), shift 0 into sb, and leave the upstream holding the instruction.
REQ-019 SHALL, on flush_i, emit a bubble, drop the instruction (instr_ready_o=1), and shift 0 into sb; flush overrides stall.
REQ-020 SHALL treat instr_valid_i=0 like a bubble, shifting 0 into sb.
REQ-021 SHALL keep x0 reading as 0 and ignore writes to it; wb_rd_i >= NREG writes SHALL be ignored.
REQ-022 SHALL, for any used register index >= NREG, set illegal_o=1 with valid_o=1 and read 0 for that operand.
REQ-023 SHALL commit a writeback at the clock edge regardless of stall or flush.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously clear all outputs, the register file, and sb to 0.
REQ-025 SHALL, on reset asserted mid-stall, discard the stall; first cycle after release, instr_ready_o=1.

Configuration
REQ-026 SHALL, with DEC_BYPASS_EN defined, forward wb_data_i to rs1/rs2 in the same cycle when rs==wb_rd_i!=0.
REQ-027 SHALL, without DEC_BYPASS_EN, read only the register file, and stall additionally when a used nonzero rs equals wb_rd_i.

Verification
REQ-028 SHALL cover: ADDI x1,x0,-1 -> next cycle valid_o=1, rd_o=1, imm_o=0xFFFFFFFF.
REQ-029 SHALL cover: ADD x3,x1,x2 immediately after write to x1, SB_DEPTH=2 -> two bubbles with instr_ready_o=0, then issue.
REQ-030 SHALL cover: wb_rd_i=5, wb_data_i=0x1234 same cycle as ADDI x6,x5,0 -> with bypass rs1_data_o=0x1234; without, one bubble, then 0x1234.
REQ-031 SHALL cover: flush_i during a stall -> bubble, instr_ready_o=1, no rd enters sb.
REQ-032 SHALL cover: NREG=16, ADD x17,x1,x2 -> illegal_o=1; write wb_rd_i=20 -> no register changes.
REQ-033 SHALL cover: rst_n low during stall -> outputs 0 immediately, instr_ready_o=1 after release.

Source files
------------

// File: rtl/dec_pipe.sv
// Purpose: RV32I decode stage with register file, in-flight rd scoreboard and hazard stall.
// Latency: one cycle from acceptance to valid_o; all outputs registered.
// Backpressure: instr_ready_o drops combinationally on a RAW hazard; flush_i overrides stall.
// Optional feature macro: DEC_BYPASS_EN forwards wb_data_i to operands in the same cycle.
// Ports: clk/rst_n; instr_i/instr_addr_i/instr_valid_i/instr_ready_o upstream handshake;
//        flush_i kill; wb_rd_i/wb_data_i writeback; decoded outputs valid_o..illegal_o.
module dec_pipe #(
    parameter int NREG     = 32,
    parameter int SB_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_i,
    input  logic [31:0] instr_addr_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic        flush_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    output logic        valid_o,
    output logic [10:0] opcode_o,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    output logic [31:0] imm_o,
    output logic [4:0]  rd_o,
    output logic [31:0] instr_addr_o,
    output logic [4:0]  shamt_o,
    output logic        illegal_o
);

    localparam int AW = (NREG == 16) ? 4 : 5;
    localparam logic [5:0] NREG6 = 6'(NREG);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    function automatic logic in_rng(input logic [4:0] r);
        return ({1'b0, r} < NREG6);
    endfunction

    logic [31:0] rf_q [NREG];
    logic [4:0]  sb_q [SB_DEPTH];

    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic        rd_use, rs1_use, rs2_use;
    logic [31:0] imm;
    logic [31:0] rs1_val, rs2_val;
    logic        hit1, hit2, hazard, stall, accept, illegal;
    logic [4:0]  sb_in;

    assign op  = instr_i[6:0];
    assign f3  = instr_i[14:12];
    assign rd  = instr_i[11:7];
    assign rs1 = instr_i[19:15];
    assign rs2 = instr_i[24:20];

    // Register usage and immediate per major opcode; FENCE/SYSTEM/unknown use nothing.
    always_comb begin
        rd_use  = 1'b0;
        rs1_use = 1'b0;
        rs2_use = 1'b0;
        imm     = '0;
        case (op)
            OP_LUI, OP_AUIPC: begin
                rd_use = 1'b1;
                imm    = {instr_i[31:12], 12'b0};
            end
            OP_JAL: begin
                rd_use = 1'b1;
                imm    = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            end
            OP_JALR, OP_LOAD, OP_IMM: begin
                rd_use  = 1'b1;
                rs1_use = 1'b1;
                imm     = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OP_BRANCH: begin
                rs1_use = 1'b1;
                rs2_use = 1'b1;
                imm     = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            end
            OP_STORE: begin
                rs1_use = 1'b1;
                rs2_use = 1'b1;
                imm     = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OP_OP: begin
                rd_use  = 1'b1;
                rs1_use = 1'b1;
                rs2_use = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand read; out-of-range and x0 read as zero.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1_use && rs1 != 5'd0 && in_rng(rs1)) rs1_val = rf_q[rs1[AW-1:0]];
        if (rs2_use && rs2 != 5'd0 && in_rng(rs2)) rs2_val = rf_q[rs2[AW-1:0]];
`ifdef DEC_BYPASS_EN
        if (rs1_use && rs1 != 5'd0 && in_rng(rs1) && rs1 == wb_rd_i) rs1_val = wb_data_i;
        if (rs2_use && rs2 != 5'd0 && in_rng(rs2) && rs2 == wb_rd_i) rs2_val = wb_data_i;
`endif
    end

    // RAW check against every in-flight rd; without forwarding the pending
    // writeback is also a hazard because the file updates only at the edge.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (sb_q[i] == rs1) hit1 = 1'b1;
            if (sb_q[i] == rs2) hit2 = 1'b1;
        end
`ifndef DEC_BYPASS_EN
        if (wb_rd_i == rs1) hit1 = 1'b1;
        if (wb_rd_i == rs2) hit2 = 1'b1;
`endif
    end

    assign hazard  = (rs1_use && rs1 != 5'd0 && hit1) || (rs2_use && rs2 != 5'd0 && hit2);
    assign stall   = instr_valid_i && !flush_i && hazard;
    assign accept  = instr_valid_i && !flush_i && !hazard;
    assign illegal = (rd_use && !in_rng(rd)) || (rs1_use && !in_rng(rs1)) || (rs2_use && !in_rng(rs2));
    assign sb_in   = (accept && rd_use) ? rd : 5'd0;

    assign instr_ready_o = !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            for (int i = 0; i < SB_DEPTH; i++) sb_q[i] <= '0;
        end else begin
            if (wb_rd_i != 5'd0 && in_rng(wb_rd_i)) rf_q[wb_rd_i[AW-1:0]] <= wb_data_i;
            sb_q[0] <= sb_in;
            for (int i = 1; i < SB_DEPTH; i++) sb_q[i] <= sb_q[i-1];
        end
    end

    logic        valid_d, valid_q, illegal_d, illegal_q;
    logic [10:0] opcode_d, opcode_q;
    logic [31:0] rs1_d, rs1_q, rs2_d, rs2_q, imm_d, imm_q, addr_d, addr_q;
    logic [4:0]  rd_d, rd_q, shamt_d, shamt_q;

    // Bubbles (stall, flush, no input) drive every output field to zero.
    always_comb begin
        valid_d   = 1'b0;
        opcode_d  = '0;
        rs1_d     = '0;
        rs2_d     = '0;
        imm_d     = '0;
        rd_d      = '0;
        addr_d    = '0;
        shamt_d   = '0;
        illegal_d = 1'b0;
        if (accept) begin
            valid_d   = 1'b1;
            opcode_d  = {(instr_i[31:25] != 7'd0), f3, op};
            rs1_d     = rs1_val;
            rs2_d     = rs2_val;
            imm_d     = imm;
            rd_d      = rd_use ? rd : 5'd0;
            addr_d    = instr_addr_i;
            shamt_d   = (op == OP_IMM && (f3 == 3'b001 || f3 == 3'b101)) ? instr_i[24:20] : 5'd0;
            illegal_d = illegal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            opcode_q  <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            rd_q      <= '0;
            addr_q    <= '0;
            shamt_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            opcode_q  <= opcode_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            imm_q     <= imm_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            shamt_q   <= shamt_d;
            illegal_q <= illegal_d;
        end
    end

    assign valid_o      = valid_q;
    assign opcode_o     = opcode_q;
    assign rs1_data_o   = rs1_q;
    assign rs2_data_o   = rs2_q;
    assign imm_o        = imm_q;
    assign rd_o         = rd_q;
    assign instr_addr_o = addr_q;
    assign shamt_o      = shamt_q;
    assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_dec_pipe.sv
module tb_dec_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_i, instr_addr_i, wb_data_i;
    logic        instr_valid_i, flush_i;
    logic [4:0]  wb_rd_i;

    logic        instr_ready_o, valid_o, illegal_o;
    logic [10:0] opcode_o;
    logic [31:0] rs1_data_o, rs2_data_o, imm_o, instr_addr_o;
    logic [4:0]  rd_o, shamt_o;

    logic        ready16, valid16, illegal16;
    logic [10:0] opcode16;
    logic [31:0] rs1d16, rs2d16, imm16, addr16;
    logic [4:0]  rd16, shamt16;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    dec_pipe #(.NREG(32), .SB_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .instr_addr_i(instr_addr_i),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .flush_i(flush_i),
        .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .valid_o(valid_o), .opcode_o(opcode_o),
        .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o), .rd_o(rd_o),
        .instr_addr_o(instr_addr_o), .shamt_o(shamt_o), .illegal_o(illegal_o)
    );

    dec_pipe #(.NREG(16), .SB_DEPTH(2)) dut16 (
        .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .instr_addr_i(instr_addr_i),
        .instr_valid_i(instr_valid_i), .instr_ready_o(ready16), .flush_i(flush_i),
        .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .valid_o(valid16), .opcode_o(opcode16),
        .rs1_data_o(rs1d16), .rs2_data_o(rs2d16), .imm_o(imm16), .rd_o(rd16),
        .instr_addr_o(addr16), .shamt_o(shamt16), .illegal_o(illegal16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Apply inputs in the low phase, then settle before any combinational check.
    task automatic put(input logic [31:0] ins, input logic v, input logic fl,
                       input logic [4:0] wr, input logic [31:0] wd);
        @(negedge clk);
        instr_i       = ins;
        instr_addr_i  = 32'h1000_0000 | {16'h0, ins[15:0]};
        instr_valid_i = v;
        flush_i       = fl;
        wb_rd_i       = wr;
        wb_data_i     = wd;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        instr_i = '0; instr_addr_i = '0; instr_valid_i = 1'b0;
        flush_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
        #12;
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_rd", {27'd0, rd_o}, 32'd0);
        chk("rst_imm", imm_o, 32'd0);
        chk("rst_ready", {31'd0, instr_ready_o}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // ADDI x1,x0,-1
        put(32'hFFF00093, 1'b1, 1'b0, 5'd0, 32'd0);
        chk("addi_ready", {31'd0, instr_ready_o}, 32'd1);
        tick();
        chk("addi_valid", {31'd0, valid_o}, 32'd1);
        chk("addi_rd", {27'd0, rd_o}, 32'd1);
        chk("addi_imm", imm_o, 32'hFFFF_FFFF);
        chk("addi_opc", {21'd0, opcode_o}, 32'h413);
        chk("addi_addr", instr_addr_o, 32'h1000_0093);

        // ADD x3,x1,x2 right behind: two bubbles then issue
        for (int i = 0; i < 2; i++) begin
            put(32'h002081B3, 1'b1, 1'b0, 5'd0, 32'd0);
            chk("raw_ready", {31'd0, instr_ready_o}, 32'd0);
            tick();
            chk("raw_bubble_valid", {31'd0, valid_o}, 32'd0);
            chk("raw_bubble_rd", {27'd0, rd_o}, 32'd0);
        end
        put(32'h002081B3, 1'b1, 1'b0, 5'd0, 32'd0);
        chk("raw_ready_go", {31'd0, instr_ready_o}, 32'd1);
        tick();
        chk("add_valid", {31'd0, valid_o}, 32'd1);
        chk("add_rd", {27'd0, rd_o}, 32'd3);
        chk("add_opc", {21'd0, opcode_o}, 32'h033);
        chk("add_imm", imm_o, 32'd0);

        // ADDI x6,x5,0 with writeback x5=0x1234 in the same cycle
        put(32'h00028313, 1'b1, 1'b0, 5'd5, 32'h1234);
`ifdef DEC_BYPASS_EN
        chk("byp_ready", {31'd0, instr_ready_o}, 32'd1);
        tick();
        chk("byp_valid", {31'd0, valid_o}, 32'd1);
        chk("byp_rs1", rs1_data_o, 32'h1234);
`else
        chk("wb_ready", {31'd0, instr_ready_o}, 32'd0);
        tick();
        chk("wb_bubble", {31'd0, valid_o}, 32'd0);
        put(32'h00028313, 1'b1, 1'b0, 5'd0, 32'd0);
        chk("wb_ready_go", {31'd0, instr_ready_o}, 32'd1);
        tick();
        chk("wb_valid", {31'd0, valid_o}, 32'd1);
        chk("wb_rs1", rs1_data_o, 32'h1234);
`endif
        chk("x6_rd", {27'd0, rd_o}, 32'd6);

        // Flush during stall: ADDI x7,x0,5 then ADDI x8,x7,1 stalled, flushed
        put(32'h00500393, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        put(32'h00138413, 1'b1, 1'b0, 5'd0, 32'd0);
        chk("fl_stall_ready", {31'd0, instr_ready_o}, 32'd0);
        tick();
        put(32'h00138413, 1'b1, 1'b1, 5'd0, 32'd0);
        chk("fl_ready", {31'd0, instr_ready_o}, 32'd1);
        tick();
        chk("fl_bubble", {31'd0, valid_o}, 32'd0);
        // ADD x9,x8,x0 would stall if rd 8 had entered sb
        put(32'h000404B3, 1'b1, 1'b0, 5'd0, 32'd0);
        chk("fl_no_sb", {31'd0, instr_ready_o}, 32'd1);
        tick();
        chk("x9_valid", {31'd0, valid_o}, 32'd1);
        chk("x9_rd", {27'd0, rd_o}, 32'd9);

        // Reset during stall: ADDI x10,x0,1 then ADDI x11,x10,0
        put(32'h00100513, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        chk("x10_valid", {31'd0, valid_o}, 32'd1);
        put(32'h00050593, 1'b1, 1'b0, 5'd0, 32'd0);
        chk("rs_stall_ready", {31'd0, instr_ready_o}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("rs_valid_async", {31'd0, valid_o}, 32'd0);
        chk("rs_rd_async", {27'd0, rd_o}, 32'd0);
        chk("rs_imm_async", imm_o, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rs_ready_after", {31'd0, instr_ready_o}, 32'd1);
        tick();
        chk("x11_valid", {31'd0, valid_o}, 32'd1);
        chk("x11_rd", {27'd0, rd_o}, 32'd11);

        // SRAI x12,x1,3
        put(32'h4030D613, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        chk("srai_shamt", {27'd0, shamt_o}, 32'd3);
        chk("srai_opc", {21'd0, opcode_o}, 32'h693);
        chk("srai_imm", imm_o, 32'h0000_0403);
        // SW x2,-4(x1)
        put(32'hFE20AE23, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        chk("sw_imm", imm_o, 32'hFFFF_FFFC);
        chk("sw_rd", {27'd0, rd_o}, 32'd0);
        chk("sw_opc", {21'd0, opcode_o}, 32'h523);
        chk("sw_shamt", {27'd0, shamt_o}, 32'd0);
        // BEQ x0,x0,-8
        put(32'hFE000CE3, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        chk("beq_imm", imm_o, 32'hFFFF_FFF8);
        // LUI x13,0x12345
        put(32'h123456B7, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        chk("lui_imm", imm_o, 32'h1234_5000);
        chk("lui_rd", {27'd0, rd_o}, 32'd13);
        // JAL x0,+8
        put(32'h0080006F, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        chk("jal_imm", imm_o, 32'd8);
        chk("jal_valid", {31'd0, valid_o}, 32'd1);
        // Idle input is a bubble
        put(32'h0080006F, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        chk("idle_bubble", {31'd0, valid_o}, 32'd0);

        // NREG=16: ADD x17,x1,x2 is illegal on the small file only
        put(32'h002088B3, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        chk("n16_illegal", {31'd0, illegal16}, 32'd1);
        chk("n16_valid", {31'd0, valid16}, 32'd1);
        chk("n32_legal", {31'd0, illegal_o}, 32'd0);
        // Writeback to x20 must not alias onto x4 of the 16-entry file
        put(32'h0, 1'b0, 1'b0, 5'd20, 32'hDEAD_BEEF);
        tick();
        put(32'h00020713, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        chk("n16_x4_unchanged", rs1d16, 32'd0);
        chk("n16_x14_rd", {27'd0, rd16}, 32'd14);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
